// File: rtl/rib_tcm_arbiter_pkg.sv
// rib_tcm_arbiter_pkg: RIB bus widths and the buffered-response record shared by the arbiter.
package rib_tcm_arbiter_pkg;
    localparam int RIB_AW = 32;
    localparam int RIB_DW = 32;
    localparam int RIB_MW = 4;
    typedef struct packed {
        logic              owner;
        logic [RIB_DW-1:0] data;
    } rsp_t;
endpackage

// File: rtl/rib_tcm_arbiter_if.sv
// rib_tcm_arbiter_if: one RIB link; master drives requests and rdy, slave drives gnt/rsp/rdata.
interface rib_tcm_arbiter_if import rib_tcm_arbiter_pkg::*; ();
    logic [RIB_AW-1:0] addr;
    logic              wrcs;
    logic [RIB_MW-1:0] mask;
    logic [RIB_DW-1:0] wdata;
    logic [RIB_DW-1:0] rdata;
    logic              req;
    logic              gnt;
    logic              rsp;
    logic              rdy;
    modport master (output addr, wrcs, mask, wdata, req, rdy, input rdata, gnt, rsp);
    modport slave  (input addr, wrcs, mask, wdata, req, rdy, output rdata, gnt, rsp);
endinterface

// File: rtl/rib_tcm_arbiter_sync_fifo.sv
// rib_sync_fifo: small synchronous FIFO with occupancy count; push while full is only taken alongside a pop.
module rib_sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rib_tcm_arbiter.sv
// rib_tcm_arbiter: two RIB masters sharing one TCM slave; round-robin grant, in-order response routing
// with a credit-limited response buffer so the slave response path never stalls.
module rib_tcm_arbiter import rib_tcm_arbiter_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    rib_tcm_arbiter_if.slave  m0,
    rib_tcm_arbiter_if.slave  m1,
    rib_tcm_arbiter_if.master s
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          last, sel, acc, credit;
    logic          owner, owner_empty, rsp_v, bypass;
    logic          rb_empty, rb_push, rb_pop;
    logic [CW-1:0] owner_cnt, rb_cnt;
    logic [CW:0]   inflight;
    logic [1:0]    full_unused;
    logic [RIB_DW-1:0] rsp_data;
    rsp_t          rb_in, rb_head;

    // Credits come from registered counts, so a pop this cycle frees its slot only next cycle.
    assign inflight = (CW+1)'(owner_cnt) + (CW+1)'(rb_cnt);
    assign credit   = inflight < (CW+1)'(DEPTH);

    always_comb begin
        sel     = (m0.req & m1.req) ? ~last : m1.req;
        s.req   = credit & (m0.req | m1.req);
        s.addr  = sel ? m1.addr  : m0.addr;
        s.wrcs  = sel ? m1.wrcs  : m0.wrcs;
        s.mask  = sel ? m1.mask  : m0.mask;
        s.wdata = sel ? m1.wdata : m0.wdata;
        s.rdy   = 1'b1;
    end

    assign acc    = s.req & s.gnt;
    assign m0.gnt = acc & ~sel;
    assign m1.gnt = acc & sel;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) last <= 1'b1;
        else if (acc) last <= sel;
    end

    // Responses with no recorded owner (e.g. issued before reset) are silently dropped.
    assign rsp_v   = s.rsp & ~owner_empty;
    assign bypass  = rsp_v & rb_empty & (owner ? m1.rdy : m0.rdy);
    assign rb_push = rsp_v & ~bypass;
    assign rb_in   = '{owner: owner, data: s.rdata};
    assign rb_pop  = ~rb_empty & (rb_head.owner ? m1.rdy : m0.rdy);

    assign m0.rsp   = rb_empty ? bypass & ~owner : ~rb_head.owner;
    assign m1.rsp   = rb_empty ? bypass & owner : rb_head.owner;
    assign rsp_data = rb_empty ? s.rdata : rb_head.data;
    assign m0.rdata = m0.rsp ? rsp_data : '0;
    assign m1.rdata = m1.rsp ? rsp_data : '0;

    rib_sync_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_owner (
        .clk   (i_clk),
        .rstn  (i_rstn),
        .push  (acc),
        .pop   (rsp_v),
        .din   (sel),
        .head  (owner),
        .count (owner_cnt),
        .full  (full_unused[0]),
        .empty (owner_empty)
    );

    rib_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_rbuf (
        .clk   (i_clk),
        .rstn  (i_rstn),
        .push  (rb_push),
        .pop   (rb_pop),
        .din   (rb_in),
        .head  (rb_head),
        .count (rb_cnt),
        .full  (full_unused[1]),
        .empty (rb_empty)
    );
endmodule

// File: tb/tb_rib_tcm_arbiter.sv
// tb_rib_tcm_arbiter: directed scenarios against a one-cycle-latency slave model.
module tb_rib_tcm_arbiter;
    logic clk = 1'b0;
    logic rstn;
    int   tests = 0;
    int   failed = 0;

    rib_tcm_arbiter_if m0 ();
    rib_tcm_arbiter_if m1 ();
    rib_tcm_arbiter_if s ();

    rib_tcm_arbiter #(.DEPTH(2)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .m0     (m0),
        .m1     (m1),
        .s      (s)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] md(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Slave answers every accepted request exactly one cycle later.
    always @(posedge clk) begin
        s.rsp   <= (s.req & s.gnt) === 1'b1;
        s.rdata <= md(s.addr);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        s.gnt = 1'b1;
        m0.req = 0; m0.addr = 0; m0.wrcs = 0; m0.mask = 0; m0.wdata = 0; m0.rdy = 1;
        m1.req = 0; m1.addr = 0; m1.wrcs = 0; m1.mask = 0; m1.wdata = 0; m1.rdy = 1;
        next();
        next();
        rstn = 1'b1;
        @(negedge clk);
        tests++; if ({m1.gnt, m0.gnt} !== 2'b00) begin failed++; $display("FAIL reset_gnt: got %b want 00", {m1.gnt, m0.gnt}); end
        tests++; if ({m1.rsp, m0.rsp} !== 2'b00) begin failed++; $display("FAIL reset_rsp: got %b want 00", {m1.rsp, m0.rsp}); end
        tests++; if (s.req !== 1'b0) begin failed++; $display("FAIL reset_sreq: got %b want 0", s.req); end
        tests++; if ({m1.rdata, m0.rdata} !== 64'h0) begin failed++; $display("FAIL reset_rdata: got %h want 0", {m1.rdata, m0.rdata}); end
        tests++; if (s.rdy !== 1'b1) begin failed++; $display("FAIL reset_srdy: got %b want 1", s.rdy); end
        next();
    endtask

    task automatic test_tie();
        logic [31:0] got;
        int p;
        m0.req = 1; m0.addr = 32'h100;
        m1.req = 1; m1.addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++; if ({m1.gnt, m0.gnt} !== ((k % 2) ? 2'b10 : 2'b01)) begin failed++; $display("FAIL tie_gnt[%0d]: got %b want %b", k, {m1.gnt, m0.gnt}, (k % 2) ? 2'b10 : 2'b01); end
            if (k > 0) begin
                p = (k - 1) % 2;
                got = p ? m1.rdata : m0.rdata;
                tests++; if ({m1.rsp, m0.rsp} !== (p ? 2'b10 : 2'b01)) begin failed++; $display("FAIL tie_rsp[%0d]: got %b want %b", k, {m1.rsp, m0.rsp}, p ? 2'b10 : 2'b01); end
                tests++; if (got !== md(p ? 32'h200 : 32'h100)) begin failed++; $display("FAIL tie_rdata[%0d]: got %h want %h", k, got, md(p ? 32'h200 : 32'h100)); end
            end
            next();
        end
        m0.req = 0; m1.req = 0;
        @(negedge clk);
        tests++; if ({m1.rsp, m0.rsp} !== 2'b10) begin failed++; $display("FAIL tie_last_rsp: got %b want 10", {m1.rsp, m0.rsp}); end
        tests++; if (m1.rdata !== md(32'h200)) begin failed++; $display("FAIL tie_last_rdata: got %h want %h", m1.rdata, md(32'h200)); end
        next();
    endtask

    task automatic test_single_read();
        m0.req = 1; m0.addr = 32'h10; m0.wrcs = 0;
        @(negedge clk);
        tests++; if ({m1.gnt, m0.gnt} !== 2'b01) begin failed++; $display("FAIL single_gnt: got %b want 01", {m1.gnt, m0.gnt}); end
        tests++; if (s.addr !== 32'h10) begin failed++; $display("FAIL single_saddr: got %h want 00000010", s.addr); end
        next();
        m0.req = 0;
        @(negedge clk);
        tests++; if ({m1.rsp, m0.rsp} !== 2'b01) begin failed++; $display("FAIL single_rsp: got %b want 01", {m1.rsp, m0.rsp}); end
        tests++; if (m0.rdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL single_rdata: got %h want deadbeef", m0.rdata); end
        next();
        @(negedge clk);
        tests++; if ({m0.rsp, m0.rdata} !== 33'h0) begin failed++; $display("FAIL single_idle: got %b/%h want 0/0", m0.rsp, m0.rdata); end
        next();
    endtask

    task automatic test_backpressure();
        m1.rdy = 0; m1.req = 1; m1.addr = 32'h300;
        @(negedge clk);
        tests++; if (m1.gnt !== 1'b1) begin failed++; $display("FAIL bp_gnt1: got %b want 1", m1.gnt); end
        next();
        m1.addr = 32'h304;
        @(negedge clk);
        tests++; if ({m1.gnt, m1.rsp} !== 2'b10) begin failed++; $display("FAIL bp_gnt2: got gnt,rsp=%b want 10", {m1.gnt, m1.rsp}); end
        next();
        m1.addr = 32'h308;
        @(negedge clk);
        tests++; if ({m1.gnt, m1.rsp} !== 2'b01) begin failed++; $display("FAIL bp_hold: got gnt,rsp=%b want 01", {m1.gnt, m1.rsp}); end
        tests++; if (m1.rdata !== md(32'h300)) begin failed++; $display("FAIL bp_head: got %h want %h", m1.rdata, md(32'h300)); end
        next();
        @(negedge clk);
        tests++; if (m1.gnt !== 1'b0) begin failed++; $display("FAIL bp_hold2: got %b want 0", m1.gnt); end
        next();
        m1.rdy = 1;
        @(negedge clk);
        tests++; if ({m1.gnt, m1.rsp} !== 2'b01) begin failed++; $display("FAIL bp_rel1: got gnt,rsp=%b want 01", {m1.gnt, m1.rsp}); end
        tests++; if (m1.rdata !== md(32'h300)) begin failed++; $display("FAIL bp_rel1_data: got %h want %h", m1.rdata, md(32'h300)); end
        next();
        @(negedge clk);
        tests++; if ({m1.gnt, m1.rsp} !== 2'b11) begin failed++; $display("FAIL bp_rel2: got gnt,rsp=%b want 11", {m1.gnt, m1.rsp}); end
        tests++; if (m1.rdata !== md(32'h304)) begin failed++; $display("FAIL bp_rel2_data: got %h want %h", m1.rdata, md(32'h304)); end
        next();
        m1.req = 0;
        @(negedge clk);
        tests++; if (m1.rsp !== 1'b1 || m1.rdata !== md(32'h308)) begin failed++; $display("FAIL bp_third: got %b/%h want 1/%h", m1.rsp, m1.rdata, md(32'h308)); end
        next();
        @(negedge clk);
        tests++; if (m1.rsp !== 1'b0) begin failed++; $display("FAIL bp_idle: got %b want 0", m1.rsp); end
        next();
    endtask

    task automatic test_hol();
        m0.rdy = 0; m1.rdy = 1;
        m0.req = 1; m0.addr = 32'h400;
        @(negedge clk);
        tests++; if (m0.gnt !== 1'b1) begin failed++; $display("FAIL hol_gnt0: got %b want 1", m0.gnt); end
        next();
        m0.req = 0; m1.req = 1; m1.addr = 32'h500;
        @(negedge clk);
        tests++; if ({m1.gnt, m0.rsp} !== 2'b10) begin failed++; $display("FAIL hol_gnt1: got gnt1,rsp0=%b want 10", {m1.gnt, m0.rsp}); end
        next();
        m1.req = 0;
        @(negedge clk);
        tests++; if ({m1.rsp, m0.rsp} !== 2'b01) begin failed++; $display("FAIL hol_block: got %b want 01", {m1.rsp, m0.rsp}); end
        tests++; if (m0.rdata !== md(32'h400)) begin failed++; $display("FAIL hol_head: got %h want %h", m0.rdata, md(32'h400)); end
        next();
        @(negedge clk);
        tests++; if (m1.rsp !== 1'b0) begin failed++; $display("FAIL hol_block2: got %b want 0", m1.rsp); end
        next();
        m0.rdy = 1;
        @(negedge clk);
        tests++; if ({m1.rsp, m0.rsp} !== 2'b01) begin failed++; $display("FAIL hol_pop0: got %b want 01", {m1.rsp, m0.rsp}); end
        next();
        @(negedge clk);
        tests++; if ({m1.rsp, m0.rsp} !== 2'b10) begin failed++; $display("FAIL hol_m1: got %b want 10", {m1.rsp, m0.rsp}); end
        tests++; if (m1.rdata !== md(32'h500)) begin failed++; $display("FAIL hol_m1_data: got %h want %h", m1.rdata, md(32'h500)); end
        next();
    endtask

    task automatic test_write();
        s.gnt = 0;
        m1.req = 1; m1.wrcs = 1; m1.addr = 32'h600; m1.wdata = 32'h1234_5678; m1.mask = 4'b0011;
        @(negedge clk);
        tests++; if ({s.req, m1.gnt} !== 2'b10) begin failed++; $display("FAIL wr_stall: got req,gnt=%b want 10", {s.req, m1.gnt}); end
        next();
        s.gnt = 1;
        @(negedge clk);
        tests++; if (m1.gnt !== 1'b1) begin failed++; $display("FAIL wr_gnt: got %b want 1", m1.gnt); end
        tests++; if ({s.wrcs, s.mask, s.wdata, s.addr} !== {1'b1, 4'b0011, 32'h1234_5678, 32'h600}) begin failed++; $display("FAIL wr_fields: got %b/%b/%h/%h want 1/0011/12345678/00000600", s.wrcs, s.mask, s.wdata, s.addr); end
        next();
        m1.req = 0; m1.wrcs = 0;
        @(negedge clk);
        tests++; if (m1.rsp !== 1'b1) begin failed++; $display("FAIL wr_rsp: got %b want 1", m1.rsp); end
        next();
    endtask

    task automatic test_reset_mid();
        m0.rdy = 0; m1.rdy = 0;
        m0.req = 1; m0.addr = 32'h700;
        @(negedge clk);
        tests++; if (m0.gnt !== 1'b1) begin failed++; $display("FAIL rmid_gnt: got %b want 1", m0.gnt); end
        next();
        m0.addr = 32'h704; rstn = 0;
        next();
        rstn = 1; m0.rdy = 1; m1.rdy = 1;
        m0.addr = 32'h710; m1.req = 1; m1.addr = 32'h720;
        @(negedge clk);
        tests++; if ({m1.rsp, m0.rsp} !== 2'b00) begin failed++; $display("FAIL rmid_drop: got %b want 00", {m1.rsp, m0.rsp}); end
        tests++; if ({m1.gnt, m0.gnt} !== 2'b01) begin failed++; $display("FAIL rmid_tie: got %b want 01", {m1.gnt, m0.gnt}); end
        next();
        m0.req = 0;
        @(negedge clk);
        tests++; if ({m1.gnt, m0.rsp} !== 2'b11 || m0.rdata !== md(32'h710)) begin failed++; $display("FAIL rmid_next: got gnt1,rsp0=%b data %h want 11 %h", {m1.gnt, m0.rsp}, m0.rdata, md(32'h710)); end
        next();
        m1.req = 0;
        @(negedge clk);
        tests++; if (m1.rsp !== 1'b1 || m1.rdata !== md(32'h720)) begin failed++; $display("FAIL rmid_m1: got %b/%h want 1/%h", m1.rsp, m1.rdata, md(32'h720)); end
        next();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_read();
        test_backpressure();
        test_hol();
        test_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/rib_tcm_arbiter.md
# rib_tcm_arbiter

Two-master to one-slave RIB arbiter placed in front of a TCM controller (ITCM/DTCM), letting the core load/store unit and a second master (DMA or debug) share one single-port TCM. It arbitrates requests round-robin, tracks in-flight transactions in issue order, and routes each slave response back to its issuing master. A credit-limited response buffer holds responses a master cannot accept yet, so the slave's response path is never back-pressured.

## Interface
- `DEPTH`, default 2: maximum in-flight transactions, counted as issued-but-unanswered plus buffered responses. Legal values are 1 to 4.
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  active-low reset, synchronous to `i_clk`.
- `i_mN_addr`  in  32  address from master N, N = 0 or 1.
- `i_mN_wrcs`  in  1  1 = write.
- `i_mN_mask`  in  4  byte-write mask.
- `i_mN_wdata`  in  32  write data.
- `o_mN_rdata`  out  32  response data to master N.
- `i_mN_req`  in  1  request.
- `o_mN_gnt`  out  1  request accepted.
- `o_mN_rsp`  out  1  response valid.
- `i_mN_rdy`  in  1  master accepts the response.
- `o_s_addr`, `o_s_wrcs`, `o_s_mask`, `o_s_wdata`  out  32/1/4/32  to the slave.
- `i_s_rdata`  in  32  slave read data, valid with `i_s_rsp`.
- `o_s_req`  out  1  request to the slave.
- `i_s_gnt`  in  1  slave accepts.
- `i_s_rsp`  in  1  slave response.
- `o_s_rdy`  out  1  tied to 1; credits guarantee buffer space.

## Operation
- **In-flight count:** `inflight = owner_cnt + rbuf_cnt`.
- **Eligibility:** master N is eligible when `i_mN_req` is high and `inflight < DEPTH`.
- **Selection:**
  - One eligible master: it is selected.
  - Both eligible: the master not named by `last` is selected.
  - `last` resets to 1, so master 0 wins the first tie.
- **Request path:**
  - `o_s_req` is 1 only when a master is selected.
  - The `o_s_*` request fields come from the selected master, or from master 0 when none is selected.
- **Grant:** `o_mN_gnt = sel==N & o_s_req & i_s_gnt`. The non-selected master's gnt is 0.
- **Accepted request** (`o_s_req & i_s_gnt`):
  - Push `sel` into the owner FIFO.
  - Set `last <= sel`.
- **Slave response** (`i_s_rsp`): pop the owner FIFO; its head is the owner.
  - **Bypass:** if the response buffer is empty and the owner's `i_mN_rdy` is high, drive the owner's rsp and rdata directly from the slave in the same cycle. The buffer is untouched.
  - **Buffer:** otherwise push {owner, `i_s_rdata`} into the response buffer.
- **Response buffer head:**
  - When the buffer is non-empty, its head drives `o_mN_rsp` and `o_mN_rdata` of the head's master.
  - The head pops when that master's `i_mN_rdy` is high.
  - Push and pop in the same cycle are both performed.
  - Delivery is strictly in order across both masters; head-of-line blocking is intended.
- **Idle outputs:** `o_mN_rdata` is 0 when `o_mN_rsp` is 0.
- **Unmatched response:** `i_s_rsp` with the owner FIFO empty is dropped and no state changes.
- **Reset** (`i_rstn` low at a clock edge):
  - Both FIFOs are emptied and `last` is set to 1.
  - Slave responses to pre-reset requests are dropped.
- **Output reset values:** all `o_mN_gnt`, `o_mN_rsp`, and `o_s_req` are 0; all rdata outputs are 0; `o_s_rdy` is 1.

## Timing
- Grant is combinational, in the same cycle as the request when credit is available.
- Slave `rsp` follows `gnt` by 1 cycle, so bypass latency from request to master `rsp` is 1 cycle.
- A buffered response leaves no earlier than 1 cycle after its push.
- The credit check uses registered counts. A response pop in the same cycle does not free a credit until the next cycle.
- With `DEPTH=2`, back-to-back grants sustain 1 transaction per cycle as long as the masters assert `rdy`.
- Masters must hold `req`, `addr`, `wrcs`, `mask`, and `wdata` stable until `gnt`.

## Structure
- Shared include for the RIB constants `RIB_AW=32`, `RIB_DW=32`, `RIB_MW=4`, alongside the core `config.v`.
- One sub-module, `rib_sync_fifo`, instanced twice:
  - parameters `WIDTH` and `DEPTH`;
  - ports push, pop, head, count, full, empty;
  - synchronous active-low reset;
  - owner FIFO at `WIDTH=1`, response buffer at `WIDTH=33`.
- Arbitration, credit, and bypass logic live in the top level.

## Test plan
- **Single master read:** m0 reads 0x0000_0010 with the slave model returning 0xDEAD_BEEF. Expect `o_m0_gnt` in cycle 0, then `o_m0_rsp=1` and `o_m0_rdata=0xDEAD_BEEF` in cycle 1, with `o_m1_rsp` staying 0.
- **Tie:** both masters request continuously. Expect grants to alternate m0, m1, m0, m1 with one grant per cycle, and each response routed to its issuer.
- **Back-pressure:** with `DEPTH=2`, m1 holds `rdy=0` and issues 3 reads. Expect grants 1 and 2 only; the third is held off while `inflight=2`. After m1 raises `rdy`, expect 2 responses in 2 cycles, in order, then the third grant.
- **Head-of-line blocking:** m0 read (rdy=0) is followed by an m1 read (rdy=1). Expect m1's response to wait until m0 accepts, then appear the cycle after.
- **Write:** m1 writes 0x1234_5678 with mask 0b0011. Expect `o_s_wdata`, `o_s_mask`, and `o_s_wrcs=1` to pass through on the grant cycle, and `o_m1_rsp` one cycle later.
- **Reset mid-operation:** assert `i_rstn=0` for 1 cycle with 2 transactions in flight. Expect empty FIFOs, all `rsp`/`gnt` at 0, and the next tie granted to m0.
